register_status_file: RTL and testbench

- Architectural register file plus per-register rename-tag table, directly downstream of the reorder-buffer commit port.
- Decoder reads source operands (value or producing ROB tag) and records the destination tag at issue.
- ROB commit writes retired results and clears the tag when it still names the committing entry.
- Rollback discards all in-flight tags; committed values are kept.

---
 rtl/register_status_file_if.sv | 49 ++++
 rtl/register_status_file.sv | 92 +++++++++
 tb/tb_register_status_file.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/register_status_file_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : register_status_file_if
// Description : Decoder, commit and rollback signals of the register status
//               file. The master modport is the decoder/ROB side that drives
//               requests. The slave modport is the register file that answers
//               operand reads.
//   rollback_in            ROB misprediction rollback
//   dec_rs1_in/dec_rs2_in  source operand indices
//   dec_Vj/Qj/Vk/Qk_out    source values and pending producer tags
//   dec_issue_in/rd/tag    destination tag recording at issue
//   commit_*               retired result write-back
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface register_status_file_if #(
    parameter int REG_IDX_W = 5,
    parameter int TAG_W     = 4,
    parameter int DATA_W    = 32
);
    logic                 rollback_in;
    logic [REG_IDX_W-1:0] dec_rs1_in;
    logic [REG_IDX_W-1:0] dec_rs2_in;
    logic [DATA_W-1:0]    dec_Vj_out;
    logic [TAG_W-1:0]     dec_Qj_out;
    logic [DATA_W-1:0]    dec_Vk_out;
    logic [TAG_W-1:0]     dec_Qk_out;
    logic                 dec_issue_in;
    logic [REG_IDX_W-1:0] dec_rd_in;
    logic [TAG_W-1:0]     dec_tag_in;
    logic                 commit_rf_signal_in;
    logic [REG_IDX_W-1:0] commit_target_in;
    logic [TAG_W-1:0]     commit_tag_in;
    logic [DATA_W-1:0]    commit_data_in;

    modport master (
        output rollback_in, dec_rs1_in, dec_rs2_in, dec_issue_in, dec_rd_in,
               dec_tag_in, commit_rf_signal_in, commit_target_in,
               commit_tag_in, commit_data_in,
        input  dec_Vj_out, dec_Qj_out, dec_Vk_out, dec_Qk_out
    );

    modport slave (
        input  rollback_in, dec_rs1_in, dec_rs2_in, dec_issue_in, dec_rd_in,
               dec_tag_in, commit_rf_signal_in, commit_target_in,
               commit_tag_in, commit_data_in,
        output dec_Vj_out, dec_Qj_out, dec_Vk_out, dec_Qk_out
    );
endinterface
`default_nettype wire

// File: rtl/register_status_file.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : register_status_file
// Description : Architectural register file with a per-register rename tag.
//               Issue records the producing ROB tag of a destination. Commit
//               writes the retired value. Commit clears the tag only while it
//               still names the committing entry. Rollback clears every tag
//               and keeps the committed values. Operand reads are
//               combinational and forward a commit that arrives in the same
//               cycle.
//   clk   clock
//   rst   synchronous active-high reset
//   bus   register_status_file_if.slave (decoder / commit / rollback)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module register_status_file #(
    parameter int REG_COUNT = 32,
    parameter int REG_IDX_W = 5,
    parameter int TAG_W     = 4,
    parameter int DATA_W    = 32
) (
    input  wire                          clk,
    input  wire                          rst,
    register_status_file_if.slave        bus
);

    logic [DATA_W-1:0] r_value [REG_COUNT];
    logic [TAG_W-1:0]  r_tag   [REG_COUNT];

    // Operand lookup. A commit forwards only if the register still waits on
    // that exact tag. Otherwise a newer producer owns the register and its
    // tag must stay visible.
    function automatic logic [DATA_W+TAG_W-1:0] read_port(
        input logic [REG_IDX_W-1:0] rs
    );
        logic [DATA_W+TAG_W-1:0] result;
        result = '0;
        if (rs != '0) begin
            if (bus.commit_rf_signal_in && (bus.commit_target_in == rs) &&
                (r_tag[rs] == bus.commit_tag_in)) begin
                result = {bus.commit_data_in, {TAG_W{1'b0}}};
            end else begin
                result = {r_value[rs], r_tag[rs]};
            end
        end
        return result;
    endfunction

    logic [DATA_W+TAG_W-1:0] w_rd1;
    logic [DATA_W+TAG_W-1:0] w_rd2;

    always_comb begin
        w_rd1 = read_port(bus.dec_rs1_in);
        w_rd2 = read_port(bus.dec_rs2_in);
    end

    assign bus.dec_Vj_out = w_rd1[DATA_W+TAG_W-1:TAG_W];
    assign bus.dec_Qj_out = w_rd1[TAG_W-1:0];
    assign bus.dec_Vk_out = w_rd2[DATA_W+TAG_W-1:TAG_W];
    assign bus.dec_Qk_out = w_rd2[TAG_W-1:0];

    // Per-entry update. The tag priority is rollback, then issue, then
    // commit-clear. An issue and a commit to the same register in one cycle
    // therefore leave the new producer's tag. The value still takes the
    // commit data. Entry 0 is held at zero.
    always_ff @(posedge clk) begin
        for (int i = 0; i < REG_COUNT; i++) begin
            if (rst || (i == 0)) begin
                r_value[i] <= '0;
                r_tag[i]   <= '0;
            end else begin
                if (bus.rollback_in) begin
                    r_tag[i] <= '0;
                end else if (bus.dec_issue_in &&
                             (bus.dec_rd_in == REG_IDX_W'(i))) begin
                    r_tag[i] <= bus.dec_tag_in;
                end else if (bus.commit_rf_signal_in &&
                             (bus.commit_target_in == REG_IDX_W'(i)) &&
                             (r_tag[i] == bus.commit_tag_in)) begin
                    r_tag[i] <= '0;
                end

                if (bus.commit_rf_signal_in &&
                    (bus.commit_target_in == REG_IDX_W'(i))) begin
                    r_value[i] <= bus.commit_data_in;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_register_status_file.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_register_status_file
// Description : Directed self-checking bench for register_status_file.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_register_status_file;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    register_status_file_if #(.REG_IDX_W(5), .TAG_W(4), .DATA_W(32)) bus ();

    register_status_file #(
        .REG_COUNT(32), .REG_IDX_W(5), .TAG_W(4), .DATA_W(32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Advance one clock edge, then let inputs settle away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rollback_in         = 1'b0;
        bus.dec_issue_in        = 1'b0;
        bus.dec_rd_in           = '0;
        bus.dec_tag_in          = '0;
        bus.commit_rf_signal_in = 1'b0;
        bus.commit_target_in    = '0;
        bus.commit_tag_in       = '0;
        bus.commit_data_in      = '0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [3:0] tg);
        bus.dec_issue_in = 1'b1;
        bus.dec_rd_in    = rd;
        bus.dec_tag_in   = tg;
    endtask

    task automatic commit(input logic [4:0] tgt, input logic [3:0] tg,
                          input logic [31:0] d);
        bus.commit_rf_signal_in = 1'b1;
        bus.commit_target_in    = tgt;
        bus.commit_tag_in       = tg;
        bus.commit_data_in      = d;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle();
        bus.dec_rs1_in = 5'd0;
        bus.dec_rs2_in = 5'd0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        bus.dec_rs1_in = 5'd5;
        bus.dec_rs2_in = 5'd0;
        #1;
        check("reset_Vj", bus.dec_Vj_out, 32'h0);
        check("reset_Qj", 32'(bus.dec_Qj_out), 32'h0);
        check("reset_Vk", bus.dec_Vk_out, 32'h0);
        check("reset_Qk", 32'(bus.dec_Qk_out), 32'h0);

        // Issue, then commit with forwarding
        issue(5'd3, 4'd4);
        tick();
        idle();
        bus.dec_rs1_in = 5'd3;
        #1;
        check("x3_pending_Qj", 32'(bus.dec_Qj_out), 32'd4);
        commit(5'd3, 4'd4, 32'hDEADBEEF);
        #1;
        check("x3_fwd_Vj", bus.dec_Vj_out, 32'hDEADBEEF);
        check("x3_fwd_Qj", 32'(bus.dec_Qj_out), 32'd0);
        tick();
        idle();
        #1;
        check("x3_stored_Vj", bus.dec_Vj_out, 32'hDEADBEEF);
        check("x3_stored_Qj", 32'(bus.dec_Qj_out), 32'd0);

        // A stale commit keeps the newer producer tag
        issue(5'd7, 4'd2);
        tick();
        issue(5'd7, 4'd5);
        tick();
        idle();
        commit(5'd7, 4'd2, 32'h11);
        bus.dec_rs1_in = 5'd7;
        #1;
        check("x7_nofwd_Qj", 32'(bus.dec_Qj_out), 32'd5);
        check("x7_nofwd_Vj", bus.dec_Vj_out, 32'h0);
        tick();
        idle();
        #1;
        check("x7_value", bus.dec_Vj_out, 32'h11);
        check("x7_keep_Qj", 32'(bus.dec_Qj_out), 32'd5);

        // Commit and issue to the same register in one cycle
        commit(5'd9, 4'd6, 32'h22);
        issue(5'd9, 4'd8);
        tick();
        idle();
        bus.dec_rs1_in = 5'd9;
        #1;
        check("x9_value", bus.dec_Vj_out, 32'h22);
        check("x9_issue_wins", 32'(bus.dec_Qj_out), 32'd8);

        // Rollback clears all tags, ignores issue, keeps values
        issue(5'd1, 4'd1);
        tick();
        issue(5'd2, 4'd2);
        tick();
        issue(5'd3, 4'd3);
        tick();
        idle();
        bus.dec_rs1_in = 5'd1;
        bus.dec_rs2_in = 5'd2;
        #1;
        check("x1_Qj", 32'(bus.dec_Qj_out), 32'd1);
        check("x2_Qk", 32'(bus.dec_Qk_out), 32'd2);
        bus.rollback_in = 1'b1;
        issue(5'd4, 4'd4);
        tick();
        idle();
        bus.dec_rs1_in = 5'd3;
        bus.dec_rs2_in = 5'd4;
        #1;
        check("rb_x3_Qj", 32'(bus.dec_Qj_out), 32'd0);
        check("rb_x3_Vj", bus.dec_Vj_out, 32'hDEADBEEF);
        check("rb_x4_Qk", 32'(bus.dec_Qk_out), 32'd0);
        bus.dec_rs1_in = 5'd7;
        bus.dec_rs2_in = 5'd9;
        #1;
        check("rb_x7_Qj", 32'(bus.dec_Qj_out), 32'd0);
        check("rb_x7_Vj", bus.dec_Vj_out, 32'h11);
        check("rb_x9_Qk", 32'(bus.dec_Qk_out), 32'd0);
        check("rb_x9_Vk", bus.dec_Vk_out, 32'h22);
        bus.dec_rs1_in = 5'd1;
        #1;
        check("rb_x1_Qj", 32'(bus.dec_Qj_out), 32'd0);

        // A commit in a rollback cycle still writes its value
        issue(5'd10, 4'd7);
        tick();
        idle();
        bus.rollback_in = 1'b1;
        commit(5'd10, 4'd3, 32'h55);
        tick();
        idle();
        bus.dec_rs1_in = 5'd10;
        #1;
        check("rb_commit_Vj", bus.dec_Vj_out, 32'h55);
        check("rb_commit_Qj", 32'(bus.dec_Qj_out), 32'd0);

        // Writes to x0 are ignored
        issue(5'd0, 4'd3);
        commit(5'd0, 4'd0, 32'hFF);
        bus.dec_rs1_in = 5'd0;
        bus.dec_rs2_in = 5'd0;
        #1;
        check("x0_fwd_Vj", bus.dec_Vj_out, 32'h0);
        tick();
        idle();
        #1;
        check("x0_Vj", bus.dec_Vj_out, 32'h0);
        check("x0_Qj", 32'(bus.dec_Qj_out), 32'd0);
        check("x0_Vk", bus.dec_Vk_out, 32'h0);

        // A read does not see an issue in the same cycle
        issue(5'd6, 4'd6);
        bus.dec_rs1_in = 5'd6;
        #1;
        check("x6_pre_issue_Qj", 32'(bus.dec_Qj_out), 32'd0);
        tick();
        idle();
        #1;
        check("x6_post_issue_Qj", 32'(bus.dec_Qj_out), 32'd6);

        // An issue with tag 0 clears the tag
        issue(5'd6, 4'd0);
        tick();
        idle();
        #1;
        check("x6_tag0_Qj", 32'(bus.dec_Qj_out), 32'd0);

        // Reset overrides commit and clears committed state
        rst = 1'b1;
        commit(5'd3, 4'd0, 32'h1234);
        tick();
        rst = 1'b0;
        idle();
        bus.dec_rs1_in = 5'd3;
        bus.dec_rs2_in = 5'd7;
        #1;
        check("rst_x3_Vj", bus.dec_Vj_out, 32'h0);
        check("rst_x7_Vk", bus.dec_Vk_out, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
